// File: rtl/safe_pkg.sv
// Shared types and width helpers for the safe_multi keypad lock.
// Optional feature macro: SAFE_LOCKOUT_BACKOFF_EN (lockout backoff).
package safe_pkg;

  // Explicit encoding so the state register reads the same in every build
  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  // Widest backoff shift applied to the base lockout duration
  localparam int unsigned MAX_BACKOFF_LEVEL = 4;

  // Bits needed to hold the values 0..n inclusive
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Lockout timer width; the backoff build must hold LOCKOUT_CYCLES*16
  function automatic int timer_w(input int lockout_cycles);
`ifdef SAFE_LOCKOUT_BACKOFF_EN
    return cnt_w(lockout_cycles * (1 << MAX_BACKOFF_LEVEL));
`else
    return cnt_w(lockout_cycles);
`endif
  endfunction

endpackage

// File: rtl/safe_multi_if.sv
// Keypad-side bus of the safe_multi lock: digit entry, commands and status.
// master = keypad decoder / controller, slave = the lock itself.
interface safe_multi_if #(
  parameter int DIGIT_W   = 4,
  parameter int PIN_LEN   = 4,
  parameter int MAX_FAILS = 3
) ();

  localparam int FW = safe_pkg::cnt_w(MAX_FAILS);
  localparam int IW = safe_pkg::cnt_w(PIN_LEN);

  logic [DIGIT_W-1:0] din;
  logic               din_valid;
  logic               relock;
  logic               prog;
  logic               unlocked;
  logic               locked_out;
  logic [FW-1:0]      fail_count;
  logic [IW-1:0]      digit_idx;

  modport master (
    output din, din_valid, relock, prog,
    input  unlocked, locked_out, fail_count, digit_idx
  );

  modport slave (
    input  din, din_valid, relock, prog,
    output unlocked, locked_out, fail_count, digit_idx
  );

endinterface

// File: rtl/safe_lockout_timer.sv
// Loadable lockout down-counter. busy while non-zero, done on the last count.
// With SAFE_LOCKOUT_BACKOFF_EN the loaded duration is doubled per lockout
// since the last successful unlock (level saturates at 4).
module safe_lockout_timer import safe_pkg::*; #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
`ifdef SAFE_LOCKOUT_BACKOFF_EN
  input  logic          clr_level,
`endif
  output logic          busy,
  output logic          done
);

  logic [TW-1:0] timer_q, timer_d;

`ifdef SAFE_LOCKOUT_BACKOFF_EN
  logic [2:0] level_q, level_d;

  // Load scaled duration, bump the backoff level, otherwise count down
  always_comb begin
    timer_d = timer_q;
    level_d = level_q;
    if (load) begin
      // Duration is sampled from the level before it increments
      timer_d = load_val << level_q;
      if (level_q < 3'(MAX_BACKOFF_LEVEL)) begin
        level_d = level_q + 3'd1;
      end
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
    if (clr_level) begin
      level_d = '0;
    end
  end

  // Timer and backoff level registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
      level_q <= '0;
    end else begin
      timer_q <= timer_d;
      level_q <= level_d;
    end
  end
`else
  // Load the fixed duration, otherwise count down to zero
  always_comb begin
    timer_d = timer_q;
    if (load) begin
      timer_d = load_val;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end
  end

  // Timer register
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign busy = (timer_q != '0);
  assign done = (timer_q == TW'(1));

endmodule

// File: rtl/safe_multi.sv
// Parametrised keypad lock: full-PIN compare after the last digit, fail
// counting with timed lockout, relock and PIN reprogramming while unlocked.
// Optional macro SAFE_LOCKOUT_BACKOFF_EN doubles each consecutive lockout.
module safe_multi import safe_pkg::*; #(
  parameter int DIGIT_W        = 4,
  parameter int PIN_LEN        = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0] DEFAULT_PIN = 16'hC0DE,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  safe_multi_if.slave  bus
);

  localparam int PW = PIN_LEN * DIGIT_W;
  localparam int FW = cnt_w(MAX_FAILS);
  localparam int IW = cnt_w(PIN_LEN);
  localparam int TW = timer_w(LOCKOUT_CYCLES);

  state_t        state_q, state_d;
  logic [PW-1:0] pin_q, pin_d;
  logic [PW-1:0] entry_q, entry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_out_q, locked_out_d;

  logic [PW-1:0] entry_shift;
  logic          last_digit;
  logic          pin_match;
  logic          tmr_load;
  logic          tmr_busy;
  logic          tmr_done;

  // New digit enters at the LSB so the first digit ends up most significant
  assign entry_shift = PW'({entry_q, bus.din});
  assign last_digit  = (int'(idx_q) == PIN_LEN - 1);
  assign pin_match   = (state_q == ENTRY) && bus.din_valid && !bus.relock &&
                       last_digit && (entry_shift == pin_q);

  safe_lockout_timer #(
    .TW(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (TW'(LOCKOUT_CYCLES)),
`ifdef SAFE_LOCKOUT_BACKOFF_EN
    .clr_level (pin_match),
`endif
    .busy      (tmr_busy),
    .done      (tmr_done)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    pin_d    = pin_q;
    entry_d  = entry_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;

    case (state_q)
      ENTRY: begin
        if (bus.relock) begin
          idx_d   = '0;
          entry_d = '0;
        end else if (bus.din_valid) begin
          entry_d = entry_shift;
          if (last_digit) begin
            // Compare only once the whole PIN is in; clear the entry
            idx_d   = '0;
            entry_d = '0;
            if (pin_match) begin
              state_d = UNLOCKED;
              fail_d  = '0;
            end else if (int'(fail_q) + 1 >= MAX_FAILS) begin
              state_d  = LOCKOUT;
              fail_d   = FW'(MAX_FAILS);
              tmr_load = 1'b1;
            end else begin
              fail_d = fail_q + FW'(1);
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      UNLOCKED: begin
        if (bus.relock) begin
          state_d = ENTRY;
          idx_d   = '0;
        end else if (bus.prog) begin
          state_d = PROGRAM;
          idx_d   = '0;
          entry_d = '0;
        end
      end

      PROGRAM: begin
        if (bus.relock) begin
          state_d = ENTRY;
          idx_d   = '0;
          entry_d = '0;
        end else if (bus.din_valid) begin
          if (last_digit) begin
            pin_d   = entry_shift;
            state_d = UNLOCKED;
            idx_d   = '0;
            entry_d = '0;
          end else begin
            entry_d = entry_shift;
            idx_d   = idx_q + IW'(1);
          end
        end
      end

      LOCKOUT: begin
        // An idle timer here can only mean corruption; leave rather than hang
        if (tmr_done || !tmr_busy) begin
          state_d = ENTRY;
          fail_d  = '0;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = ENTRY;
        idx_d   = '0;
        entry_d = '0;
      end
    endcase

    unlocked_d   = (state_d == UNLOCKED) || (state_d == PROGRAM);
    locked_out_d = (state_d == LOCKOUT);
  end

  // State, PIN, entry and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ENTRY;
      pin_q        <= DEFAULT_PIN;
      entry_q      <= '0;
      idx_q        <= '0;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pin_q        <= pin_d;
      entry_q      <= entry_d;
      idx_q        <= idx_d;
      fail_q       <= fail_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign bus.unlocked   = unlocked_q;
  assign bus.locked_out = locked_out_q;
  assign bus.fail_count = fail_q;
  assign bus.digit_idx  = idx_q;

endmodule

// File: doc/safe_multi.md
Name: safe_multi

Overview:
- Parametrised successor to the team's fixed-PIN keypad lock FSM.
- Takes a PIN of configurable length and digit width, then compares it only after the last digit, so no early rejection leaks which digit was wrong.
- Counts failed attempts and enforces a timed lockout instead of a permanent one.
- Supports relocking, and reprogramming the PIN while unlocked.
- Sits behind the keypad decoder; `unlocked` drives the actuator enable.

Parameters:
- DIGIT_W, 4, bits per entered digit.
- PIN_LEN, 4, number of digits per PIN (≥1).
- DEFAULT_PIN, 16'hC0DE, reset PIN, PIN_LEN*DIGIT_W bits; the first digit entered is the most-significant digit.
- MAX_FAILS, 3, number of consecutive mismatches that triggers lockout (≥1).
- LOCKOUT_CYCLES, 16, base lockout duration in clk cycles (≥1).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- din  in  DIGIT_W  entered digit.
- din_valid  in  1  din is valid this cycle; one digit per asserted cycle.
- relock  in  1  1-cycle command: lock again / abort the current entry.
- prog  in  1  1-cycle command: start PIN reprogramming; honoured only in UNLOCKED.
- unlocked  out  1  high while in UNLOCKED or PROGRAM.
- locked_out  out  1  high while in LOCKOUT.
- fail_count  out  $clog2(MAX_FAILS+1)  current count of consecutive failed attempts.
- digit_idx  out  $clog2(PIN_LEN+1)  number of digits captured in the current entry.

Behaviour:
- Reset (reset==0 at posedge):
  - state=ENTRY, pin_reg=DEFAULT_PIN, digit_idx=0, fail_count=0, timer=0.
  - unlocked=0, locked_out=0.
  - Reset has priority over all other inputs and takes effect mid-entry, mid-program and mid-lockout.
- All outputs are registered.
- States: ENTRY, UNLOCKED, PROGRAM, LOCKOUT. Unused state encodings return to ENTRY.
- ENTRY:
  - Each din_valid cycle shifts din into the entry shift register and increments digit_idx.
  - On the cycle the PIN_LEN-th digit is accepted, the full value is compared with pin_reg.
  - Match: next state UNLOCKED, fail_count=0, digit_idx=0. unlocked=1 on the following cycle (1-cycle latency from the last digit).
  - Mismatch with fail_count+1 < MAX_FAILS: fail_count++, digit_idx=0, stay in ENTRY.
  - Mismatch with fail_count+1 == MAX_FAILS: go to LOCKOUT, timer=lockout duration, fail_count = MAX_FAILS.
  - relock in ENTRY: digit_idx=0, partial entry discarded, no fail counted. relock beats a simultaneous din_valid.
- LOCKOUT:
  - din_valid, prog and relock are ignored.
  - timer decrements once per cycle. When timer==1, next state is ENTRY with fail_count=0 and digit_idx=0.
  - locked_out is high for exactly the lockout duration in cycles.
- UNLOCKED:
  - din_valid is ignored.
  - relock: go to ENTRY.
  - prog (without relock): go to PROGRAM, digit_idx=0.
  - relock and prog in the same cycle: relock wins.
- PROGRAM:
  - Digits shift into the entry register as in ENTRY.
  - After PIN_LEN digits: pin_reg=entered value, return to UNLOCKED.
  - relock: abort, pin_reg unchanged, go to ENTRY.
- Digits never leak: no output depends on whether a partially entered PIN matches so far.
- pin_reg persists across relock and lockout; only reset restores DEFAULT_PIN.

Optional Feature:
- Macro: SAFE_LOCKOUT_BACKOFF_EN.
- Defined:
  - A 3-bit lockout_level counts lockouts since the last successful unlock, saturating at 4.
  - Lockout duration = LOCKOUT_CYCLES << lockout_level, sampled on LOCKOUT entry before lockout_level increments.
  - lockout_level clears on a match and on reset.
  - Timer width = $clog2(LOCKOUT_CYCLES*16+1).
- Undefined: duration is always LOCKOUT_CYCLES; no lockout_level register is present.

Decomposition:
- Package safe_pkg holds the state_t enum, explicitly numbered (ENTRY=0, UNLOCKED=1, PROGRAM=2, LOCKOUT=3).
- safe_pkg also holds the width helper constants.
- One sub-module, safe_lockout_timer: loadable down-counter with a load value input, a busy output and a done pulse. It also holds the backoff level when the feature is enabled.

Test Plan:
- Default parameters, enter C,0,D,E → unlocked=1 one cycle after E; fail_count=0.
- Enter C,1,D,E → unlocked stays 0, fail_count=1, digit_idx=0. The wrong digit is not flagged before the 4th digit.
- Three wrong PINs → locked_out=1 for exactly 16 cycles. Digits entered during lockout have no effect. Afterwards fail_count=0 and C,0,D,E unlocks.
- Unlock, pulse prog, enter 1,2,3,4, pulse relock → C,0,D,E fails; 1,2,3,4 unlocks. Then reset=0 for one cycle → C,0,D,E unlocks again.
- Partial entry C,0 then relock → digit_idx=0, fail_count unchanged. relock+prog together in UNLOCKED → ENTRY.
- With SAFE_LOCKOUT_BACKOFF_EN defined, three consecutive lockouts → durations 16, 32, 64 cycles. After a successful unlock the next lockout is 16 cycles.
